// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//
// Shared definitions for the SDRAM write-burst path.
//   - Default widths and burst length used by the write-path modules.
//   - FSM state encoding for the write-burst controller.
//   - cnt_width(): width of the pop/beat counters for a given burst length.
//     The width is clog2(burst_len)+1, so a counter can hold the value
//     burst_len itself without wrapping, even at the maximum length of 256.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int DEF_FIFO_WIDTH    = 16;
    localparam int DEF_POINTER_WIDTH = 9;
    localparam int DEF_BURST_LEN     = 8;
    localparam int DEF_ADDR_WIDTH    = 22;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_WAIT = 2'd3
    } wr_state_e;

    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// -----------------------------------------------------------------------------
// sdram_wr_addr_gen
//
// Holds the linear start address of the current/next SDRAM write burst.
// On each advance strobe the address moves forward by one burst; when the
// burst that just completed started at END_ADDR, the address wraps back to
// BASE_ADDR instead.
//
// Ports:
//   clk      in   SDRAM clock
//   rst      in   asynchronous, active-high reset (address -> BASE_ADDR)
//   advance  in   one-cycle strobe: the burst at wr_addr has completed
//   wr_addr  out  start address of the current/next burst
// -----------------------------------------------------------------------------
module sdram_wr_addr_gen
    import sdram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    BURST_LEN  = DEF_BURST_LEN,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   =
        ADDR_WIDTH'((64'd1 << ADDR_WIDTH) - 64'(BURST_LEN))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN);

    // The wrap decision uses the address of the burst that just finished,
    // so END_ADDR itself is still used as a burst start before wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= BASE_ADDR;
        end else if (advance) begin
            if (wr_addr == END_ADDR) begin
                wr_addr <= BASE_ADDR;
            end else begin
                wr_addr <= wr_addr + ADDR_STEP;
            end
        end
    end

endmodule

// File: rtl/sdram_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_wr_burst_ctrl
//
// Write-path stage between the write-side async FIFO (read port) and the
// SDRAM command engine, running in the SDRAM clock domain. Once a full burst
// is buffered in the FIFO it requests the command engine, pops exactly
// BURST_LEN words, streams them as wr_data/wr_data_valid beats with a fixed
// one-cycle latency from pop to beat, then waits for the engine to finish
// the burst before advancing the wrapping write address.
//
// Ports:
//   clk              in   SDRAM clock (also the FIFO read clock)
//   rst              in   asynchronous, active-high reset
//   init_done        in   SDRAM initialisation complete
//   fifo_data_count  in   FIFO read-side fill level (0..depth)
//   fifo_empty       in   FIFO empty
//   fifo_dout        in   FIFO read data, valid the cycle after a pop
//   fifo_ren         out  FIFO pop strobe
//   wr_req           out  burst request to the command arbiter
//   wr_grant         in   single-cycle grant pulse
//   wr_addr          out  burst start address, stable for the whole burst
//   wr_data          out  burst data word
//   wr_data_valid    out  one pulse per data beat
//   wr_done          in   single-cycle pulse: engine finished the burst
//   busy             out  high in every state except IDLE
//   underrun         out  sticky: FIFO ran empty mid-burst
// -----------------------------------------------------------------------------
module sdram_wr_burst_ctrl
    import sdram_pkg::*;
#(
    parameter int                    FIFO_WIDTH    = DEF_FIFO_WIDTH,
    parameter int                    POINTER_WIDTH = DEF_POINTER_WIDTH,
    parameter int                    BURST_LEN     = DEF_BURST_LEN,
    parameter int                    ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR      =
        ADDR_WIDTH'((64'd1 << ADDR_WIDTH) - 64'(BURST_LEN))
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_done,
    input  logic [POINTER_WIDTH-1:0] fifo_data_count,
    input  logic                     fifo_empty,
    input  logic [FIFO_WIDTH-1:0]    fifo_dout,
    output logic                     fifo_ren,
    output logic                     wr_req,
    input  logic                     wr_grant,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [FIFO_WIDTH-1:0]    wr_data,
    output logic                     wr_data_valid,
    input  logic                     wr_done,
    output logic                     busy,
    output logic                     underrun
);

    localparam int                       CNT_W        = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0]         BURST_CNT    = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]         LAST_BEAT    = CNT_W'(BURST_LEN - 1);
    // BURST_LEN never exceeds the FIFO depth, so it fits in the count width;
    // a count equal to the depth (MSB set) compares correctly as unsigned.
    localparam logic [POINTER_WIDTH-1:0] BURST_THRESH = POINTER_WIDTH'(BURST_LEN);

    wr_state_e        state;
    wr_state_e        next_state;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic             addr_advance;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. XFER ends on the edge that retires the last beat,
    // so no beat is ever presented while in WAIT.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (init_done && (fifo_data_count >= BURST_THRESH)) begin
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (wr_grant) begin
                    next_state = S_XFER;
                end
            end
            S_XFER: begin
                if (wr_data_valid && (beat_cnt == LAST_BEAT)) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode. The pop strobe is gated by fifo_empty so the FIFO is
    // never read while empty; a stall simply holds pop_cnt.
    always_comb begin
        fifo_ren = 1'b0;
        wr_req   = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE:  busy     = 1'b0;
            S_REQ:   wr_req   = 1'b1;
            S_XFER:  fifo_ren = (pop_cnt < BURST_CNT) && !fifo_empty;
            default: ;
        endcase
    end

    // Burst counters, beat qualifier and underrun flag. The counters are
    // cleared on the grant edge so each burst starts from zero; the beat
    // qualifier is the pop strobe delayed by exactly one cycle, matching the
    // FIFO read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt       <= '0;
            beat_cnt      <= '0;
            wr_data_valid <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            wr_data_valid <= fifo_ren;
            if ((state == S_REQ) && wr_grant) begin
                pop_cnt  <= '0;
                beat_cnt <= '0;
            end else begin
                if (fifo_ren) begin
                    pop_cnt <= pop_cnt + 1'b1;
                end
                if (wr_data_valid) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if ((state == S_XFER) && fifo_empty && (pop_cnt < BURST_CNT)) begin
                underrun <= 1'b1;
            end
        end
    end

    // The FIFO presents the popped word during the beat cycle, so the data
    // output passes it through while the beat is valid and is zero otherwise.
    assign wr_data = wr_data_valid ? fifo_dout : '0;

    assign addr_advance = (state == S_WAIT) && wr_done;

    sdram_wr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .BASE_ADDR  (BASE_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (addr_advance),
        .wr_addr (wr_addr)
    );

endmodule

// File: doc/sdram_wr_burst_ctrl.md
Name: sdram_wr_burst_ctrl

Overview:
Write-path stage directly downstream of the write-side async FIFO, running in the SDRAM clock domain.
- Watches the FIFO read-side fill level and, once a full burst is buffered, arbitrates for the SDRAM command engine.
- Pops exactly BURST_LEN words and streams them with a per-burst start address.
- Advances a wrapping linear write address after each completed burst.

Parameters:
FIFO_WIDTH, 16, data word width (matches FIFO width)
POINTER_WIDTH, 9, FIFO pointer/data_count width (depth = 2^(POINTER_WIDTH-1))
BURST_LEN, 8, words per SDRAM write burst; power of two, 1..256, <= FIFO depth
ADDR_WIDTH, 22, linear word address width ({bank,row,col})
BASE_ADDR, 0, first burst address after reset/wrap
END_ADDR, 2^ADDR_WIDTH-BURST_LEN, last legal burst start address

Ports:
clk  in  1  SDRAM clock, also FIFO r_clk
rst  in  1  asynchronous, active-high reset
init_done  in  1  SDRAM init sequence complete
fifo_data_count  in  POINTER_WIDTH  FIFO read-side fill level, unsigned 0..depth
fifo_empty  in  1  FIFO empty
fifo_dout  in  FIFO_WIDTH  FIFO read data, valid the cycle after a successful pop
fifo_ren  out  1  FIFO pop strobe
wr_req  out  1  burst request to command arbiter
wr_grant  in  1  single-cycle grant pulse
wr_addr  out  ADDR_WIDTH  burst start address, stable from wr_req high until done
wr_data  out  FIFO_WIDTH  burst data word
wr_data_valid  out  1  wr_data qualifier, one per beat
wr_done  in  1  single-cycle pulse: command engine finished burst (incl. precharge)
busy  out  1  high in every state except IDLE
underrun  out  1  sticky error flag: FIFO ran empty mid-burst

Behaviour:
Reset (async, rst=1): state IDLE; fifo_ren, wr_req, wr_data_valid, busy, underrun = 0; wr_data = 0; wr_addr = BASE_ADDR; beat counters = 0. Reset mid-burst aborts immediately; no recovery of words already popped.

FSM states:
- IDLE: go to REQ when init_done=1 and fifo_data_count >= BURST_LEN. Compare is unsigned at POINTER_WIDTH bits. The count value equal to depth (MSB set) is legal.
- REQ: wr_req=1. On wr_grant go to XFER; wr_req drops the same edge. No timeout.
- XFER:
  - fifo_ren = (pop_cnt < BURST_LEN) & ~fifo_empty.
  - pop_cnt increments on each successful pop.
  - wr_data_valid is a 1-cycle registered copy of the successful pop; wr_data captures fifo_dout on that cycle.
  - Fixed latency: pop at cycle N -> wr_data_valid at N+1.
  - If fifo_empty while pop_cnt < BURST_LEN: stall (no pop) and set underrun.
  - Go to WAIT when beat_cnt reaches BURST_LEN (last valid beat issued).
- WAIT: go to IDLE on wr_done. On that same edge, wr_addr += BURST_LEN; if the old wr_addr == END_ADDR, wr_addr = BASE_ADDR.
  - wr_done outside WAIT is ignored.

Rules:
- Total pops per burst = total valid beats = BURST_LEN, exactly.
- Minimum gap between bursts is 1 IDLE cycle.
- Counters are width clog2(BURST_LEN)+1 so BURST_LEN=256 does not wrap.
- fifo_ren is never asserted while fifo_empty=1.

Decomposition:
- Package sdram_pkg: FIFO_WIDTH, POINTER_WIDTH, BURST_LEN, ADDR_WIDTH defaults, and the FSM state encoding (IDLE/REQ/XFER/WAIT, 2-bit).
- One sub-module, sdram_wr_addr_gen: holds wr_addr, and increments by BURST_LEN with BASE/END wrap on an advance strobe.

Test Plan:
1. init_done=0, data_count=16 -> wr_req stays 0; raise init_done -> wr_req=1 next cycle, wr_addr=0.
2. data_count=8, grant, FIFO holds 0xA0..0xA7 -> 8 fifo_ren cycles, wr_data_valid 8 beats each one cycle after its pop, data 0xA0..0xA7 in order; wr_done -> wr_addr=8.
3. data_count=7 for 100 cycles -> no wr_req; count=8 -> wr_req next cycle.
4. wr_addr=END_ADDR, complete burst -> wr_addr=BASE_ADDR after wr_done; next burst uses BASE_ADDR.
5. Force fifo_empty=1 after 3 pops -> fifo_ren 0, beats stall at 3, underrun=1; release -> remaining 5 beats, state WAIT, underrun still 1.
6. Assert rst during beat 4 -> all outputs zero and wr_addr=BASE_ADDR asynchronously; after release, new burst requires count>=8 and starts at BASE_ADDR.
